// File: rtl/top_pkg.sv
// Shared definitions for the demo accumulator CPU and its seven-segment display.
package top_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXECUTE   = 4'd2,
    WRITEBACK = 4'd3,
    HALT      = 4'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_SHL4 = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a}; element i is the pattern for hex digit i.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/top_seven_seg_mux.sv
// Four-digit multiplexed seven-segment driver: shows a 16-bit value in hex.
module seven_seg_mux
  import top_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [3:0]  anode,
  output logic [7:0]  catode
);

  localparam int unsigned CW = REFRESH_BITS + 2;

  logic [CW-1:0] refresh;
  logic [1:0]    sel;
  logic [3:0]    nib;

  assign sel = refresh[CW-1 -: 2];

  always_comb begin
    nib = value[3:0];
    case (sel)
      2'd0: nib = value[3:0];
      2'd1: nib = value[7:4];
      2'd2: nib = value[11:8];
      2'd3: nib = value[15:12];
      default: nib = value[3:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh <= '0;
      anode   <= 4'b1110;
      catode  <= SEG_LUT[0];
    end else begin
      refresh <= refresh + CW'(1);
      anode   <= ~(4'b0001 << sel);
      catode  <= SEG_LUT[nib];
    end
  end

endmodule

// File: rtl/top.sv
// Multicycle accumulator CPU running a fixed ROM program, with its accumulator
// shown in hex on a multiplexed seven-segment display.
module top
  import top_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] anode,
  output logic [7:0] catode,
  output logic [3:0] state
);

  state_t      cur, nxt;
  logic [3:0]  pc;
  logic [7:0]  ir;
  logic [15:0] acc;
  logic [15:0] res;
  logic [3:0]  opcode;
  logic [3:0]  imm;

  assign opcode = ir[7:4];
  assign imm    = ir[3:0];
  assign state  = cur;

  function automatic logic [7:0] rom_read(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_read = 8'h11;
      4'd1:    rom_read = 8'h42;
      4'd2:    rom_read = 8'h43;
      4'd3:    rom_read = 8'h44;
      4'd4:    rom_read = 8'hF0;
      default: rom_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:     nxt = DECODE;
      DECODE:    nxt = (opcode == OP_HALT) ? HALT : EXECUTE;
      EXECUTE:   nxt = WRITEBACK;
      WRITEBACK: nxt = FETCH;
      HALT:      nxt = HALT;
      default:   nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      res <= '0;
    end else begin
      case (cur)
        FETCH: begin
          ir <= rom_read(pc);
          pc <= pc + 4'd1;
        end
        EXECUTE: begin
          case (opcode)
            OP_LDI:  res <= {12'h000, imm};
            OP_ADDI: res <= acc + {12'h000, imm};
            OP_SUBI: res <= acc - {12'h000, imm};
            OP_SHL4: res <= {acc[11:0], imm};
            OP_JMP: begin
              res <= acc;
              pc  <= imm;
            end
            default: res <= acc;
          endcase
        end
        WRITEBACK: begin
          if (opcode == OP_LDI || opcode == OP_ADDI ||
              opcode == OP_SUBI || opcode == OP_SHL4)
            acc <= res;
        end
        default: ;
      endcase
    end
  end

  seven_seg_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_disp (
    .clk    (clk),
    .reset  (reset),
    .value  (acc),
    .anode  (anode),
    .catode (catode)
  );

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: instruction-level reference model plus display model.
module tb_top;

  localparam int unsigned RB = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] anode;
  logic [7:0] catode;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  top #(.REFRESH_BITS(RB)) dut (
    .clk    (clk),
    .reset  (reset),
    .anode  (anode),
    .catode (catode),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_rom [16];
  logic [7:0]  m_seg [16];
  logic [15:0] m_acc;
  logic [3:0]  m_pc;
  int          m_phase;
  bit          m_halt;
  int          m_ref;
  logic [3:0]  m_an;
  logic [7:0]  m_cat;

  function automatic logic [3:0] m_state();
    return m_halt ? 4'd4 : 4'(m_phase);
  endfunction

  task automatic model_step(input bit r);
    int sel;
    logic [7:0] ins;
    if (r) begin
      m_acc = '0; m_pc = '0; m_phase = 0; m_halt = 0; m_ref = 0;
      m_an = 4'b1110; m_cat = 8'hC0;
    end else begin
      sel   = m_ref >> RB;
      m_an  = ~(4'b0001 << sel);
      m_cat = m_seg[(m_acc >> (4 * sel)) & 16'hF];
      m_ref = (m_ref + 1) % (1 << (RB + 2));
      if (!m_halt) begin
        ins = m_rom[m_pc];
        if (m_phase == 1 && ins[7:4] == 4'hF) m_halt = 1;
        else if (m_phase == 3) begin
          case (ins[7:4])
            4'h1: m_acc = {12'h0, ins[3:0]};
            4'h2: m_acc = m_acc + {12'h0, ins[3:0]};
            4'h3: m_acc = m_acc - {12'h0, ins[3:0]};
            4'h4: m_acc = {m_acc[11:0], ins[3:0]};
            default: ;
          endcase
          m_pc    = (ins[7:4] == 4'h5) ? ins[3:0] : m_pc + 4'd1;
          m_phase = 0;
        end else m_phase++;
      end
    end
  endtask

  task automatic tick(input bit r);
    @(negedge clk);
    reset = r;
    @(posedge clk);
    #1;
    model_step(r);
  endtask

  task automatic test_reset();
    tick(1);
    n_cmp++;
    if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state got=%0d want=0", state); end
    n_cmp++;
    if (anode !== 4'b1110) begin n_bad++; $display("FAIL reset_anode got=%b want=1110", anode); end
    n_cmp++;
    if (catode !== 8'hC0) begin n_bad++; $display("FAIL reset_catode got=%h want=c0", catode); end
    n_cmp++;
    if (dut.acc !== 16'h0000) begin n_bad++; $display("FAIL reset_acc got=%h want=0000", dut.acc); end
  endtask

  task automatic test_program_run();
    logic [15:0] milestones [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
    for (int e = 1; e <= 116; e++) begin
      tick(0);
      n_cmp++;
      if ({state, anode, catode} !== {m_state(), m_an, m_cat}) begin
        n_bad++;
        $display("FAIL run_cycle e=%0d got st=%0d an=%b cat=%h want st=%0d an=%b cat=%h",
                 e, state, anode, catode, m_state(), m_an, m_cat);
      end
      if (e % 4 == 0 && e <= 16) begin
        n_cmp++;
        if (dut.acc !== milestones[e/4-1]) begin
          n_bad++; $display("FAIL run_acc e=%0d got=%h want=%h", e, dut.acc, milestones[e/4-1]);
        end
      end
    end
    n_cmp++;
    if (state !== 4'd4) begin n_bad++; $display("FAIL halt_state got=%0d want=4", state); end
    n_cmp++;
    if (dut.acc !== 16'h1234) begin n_bad++; $display("FAIL halt_acc got=%h want=1234", dut.acc); end
  endtask

  task automatic test_halt_display();
    int seen = 0;
    for (int c = 0; c < 16; c++) begin
      logic [7:0] want;
      tick(0);
      case (anode)
        4'b1110: want = 8'h99;
        4'b1101: want = 8'hB0;
        4'b1011: want = 8'hA4;
        4'b0111: want = 8'hF9;
        default: want = 8'hXX;
      endcase
      n_cmp++;
      if (catode !== want || anode !== m_an) begin
        n_bad++;
        $display("FAIL halt_disp c=%0d got an=%b cat=%h want an=%b cat=%h", c, anode, catode, m_an, want);
      end
      if (c > 0 && anode != 4'b1110 && anode != m_an) seen = -1;
    end
    n_cmp++;
    if (state !== 4'd4) begin n_bad++; $display("FAIL halt_display_state got=%0d want=4", state); end
  endtask

  task automatic test_reset_in_halt();
    tick(1);
    n_cmp++;
    if ({state, anode, catode, dut.acc} !== {4'd0, 4'b1110, 8'hC0, 16'h0000}) begin
      n_bad++;
      $display("FAIL halt_reset got st=%0d an=%b cat=%h acc=%h want st=0 an=1110 cat=c0 acc=0000",
               state, anode, catode, dut.acc);
    end
    for (int e = 1; e <= 24; e++) begin
      tick(0);
      n_cmp++;
      if ({state, anode, catode} !== {m_state(), m_an, m_cat}) begin
        n_bad++;
        $display("FAIL rerun_cycle e=%0d got st=%0d an=%b cat=%h want st=%0d an=%b cat=%h",
                 e, state, anode, catode, m_state(), m_an, m_cat);
      end
    end
    n_cmp++;
    if (dut.acc !== 16'h1234) begin n_bad++; $display("FAIL rerun_acc got=%h want=1234", dut.acc); end
  endtask

  task automatic test_reset_mid_execute();
    tick(1);
    for (int e = 1; e <= 10; e++) tick(0);
    n_cmp++;
    if (state !== 4'd2 || dut.acc !== 16'h0012) begin
      n_bad++; $display("FAIL pre_abort got st=%0d acc=%h want st=2 acc=0012", state, dut.acc);
    end
    tick(1);
    tick(0); tick(0);
    n_cmp++;
    if (dut.acc !== 16'h0000) begin n_bad++; $display("FAIL abort_acc got=%h want=0000", dut.acc); end
    tick(0); tick(0);
    n_cmp++;
    if (dut.acc !== 16'h0001 || state !== 4'd0) begin
      n_bad++; $display("FAIL restart got acc=%h st=%0d want acc=0001 st=0", dut.acc, state);
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 25; it++) begin
      int run = $urandom_range(0, 30);
      int rlen = $urandom_range(1, 3);
      for (int c = 0; c < run + rlen; c++) begin
        tick(c >= run);
        n_cmp++;
        if ({state, anode, catode, dut.acc} !== {m_state(), m_an, m_cat, m_acc}) begin
          n_bad++;
          $display("FAIL rand it=%0d c=%0d got st=%0d an=%b cat=%h acc=%h want st=%0d an=%b cat=%h acc=%h",
                   it, c, state, anode, catode, dut.acc, m_state(), m_an, m_cat, m_acc);
        end
      end
    end
  endtask

  initial begin
    m_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int i = 0; i < 16; i++) m_rom[i] = 8'h00;
    m_rom[0] = 8'h11; m_rom[1] = 8'h42; m_rom[2] = 8'h43; m_rom[3] = 8'h44; m_rom[4] = 8'hF0;
    model_step(1);

    test_reset();
    test_program_run();
    test_halt_display();
    test_reset_in_halt();
    test_reset_mid_execute();
    test_random_resets();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
